// File: rtl/bp_coh_wormhole_inject_arb_pkg.sv
// Shared definitions for the coherence-NoC wormhole injection arbiter.
//   inj_state_e  : arbiter FSM states (idle / burst)
//   extract_len  : pulls the wormhole length field out of a header flit
package bp_coh_inject_arb_pkg;

    typedef enum logic {
        e_inj_idle,
        e_inj_burst
    } inj_state_e;

    // Widest flit extract_len accepts; callers zero-extend into this width.
    localparam int unsigned max_flit_width_lp = 1024;

    // Returns flit[lsb +: width], zero-extended to 32 bits.
    function automatic logic [31:0] extract_len(
        input logic [max_flit_width_lp-1:0] flit,
        input int unsigned                  lsb,
        input int unsigned                  width
    );
        logic [max_flit_width_lp-1:0] shifted;
        logic [31:0]                  mask;
        shifted = flit >> lsb;
        mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/bp_coh_wormhole_inject_arb_if.sv
// Handshake bundle between tile packet sources, the injection arbiter and
// the router local input port.
//   data_i/v_i/ready_and_o : per-requester flit, valid, ready_and
//   data_o/v_o/ready_and_i : arbitrated link to the router
// slave  : arbiter view
// master : environment view (sources + router)
interface bp_coh_wormhole_inject_arb_if #(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned flit_width_p = 64
);
    logic [num_req_p*flit_width_p-1:0] data_i;
    logic [num_req_p-1:0]              v_i;
    logic [num_req_p-1:0]              ready_and_o;
    logic [flit_width_p-1:0]           data_o;
    logic                              v_o;
    logic                              ready_and_i;

    modport slave (
        input  data_i, v_i, ready_and_i,
        output ready_and_o, data_o, v_o
    );

    modport master (
        output data_i, v_i, ready_and_i,
        input  ready_and_o, data_o, v_o
    );
endinterface

// File: rtl/bp_rr_pick.sv
// Combinational round-robin pick: first set v_i bit searching upward from
// last_grant_i+1 (mod num_req_p).
//   v_i          : request vector
//   last_grant_i : most recently granted index
//   pick_o       : chosen index (0 when any_v_o=0)
//   any_v_o      : at least one request present
module bp_rr_pick #(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned lg_num_req_p = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]    v_i,
    input  logic [lg_num_req_p-1:0] last_grant_i,
    output logic [lg_num_req_p-1:0] pick_o,
    output logic                    any_v_o
);
    always_comb begin
        int unsigned idx;
        pick_o  = '0;
        any_v_o = 1'b0;
        // Scan farthest-first so the nearest candidate after last_grant_i
        // is the final (winning) assignment.
        for (int unsigned k = num_req_p; k >= 1; k--) begin
            idx = (32'(last_grant_i) + k) % num_req_p;
            if (v_i[idx]) begin
                pick_o  = lg_num_req_p'(idx);
                any_v_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bp_coh_wormhole_inject_arb.sv
// Packet-granular round-robin arbiter sharing one ready_and injection link
// among num_req_p sources. The grant locks from the header handshake until
// the last payload flit of the wormhole packet is accepted.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   link           : requester and router handshake bundle (slave modport)
//   grant_id_o     : index currently driving link.data_o
//   busy_o         : multi-flit packet in progress
module bp_coh_wormhole_inject_arb
    import bp_coh_inject_arb_pkg::*;
#(
    parameter int unsigned num_req_p     = 4,
    parameter int unsigned flit_width_p  = 64,
    parameter int unsigned len_width_p   = 4,
    parameter int unsigned len_lsb_p     = 8,
    localparam int unsigned lg_num_req_lp = $clog2(num_req_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_coh_wormhole_inject_arb_if.slave link,
    output logic [lg_num_req_lp-1:0] grant_id_o,
    output logic                     busy_o
);
    inj_state_e               state_r, state_n;
    logic [len_width_p-1:0]   cnt_r, cnt_n;
    logic [lg_num_req_lp-1:0] lock_r, lock_n;
    logic [lg_num_req_lp-1:0] last_grant_r, last_grant_n;

    logic [lg_num_req_lp-1:0] pick, cur_id;
    logic                     any_v, v_raw, hs;
    logic [len_width_p-1:0]   hdr_len;

    bp_rr_pick #(
        .num_req_p   (num_req_p),
        .lg_num_req_p(lg_num_req_lp)
    ) u_pick (
        .v_i         (link.v_i),
        .last_grant_i(last_grant_r),
        .pick_o      (pick),
        .any_v_o     (any_v)
    );

    always_comb begin
        cur_id = last_grant_r;
        if (state_r == e_inj_burst) begin
            cur_id = lock_r;
        end else if (any_v) begin
            cur_id = pick;
        end
    end

    always_comb begin
        int unsigned base;
        base        = 32'(cur_id) * flit_width_p;
        link.data_o = link.data_i[base +: flit_width_p];
    end

    // Outputs are forced quiet while reset_i is high, independent of the
    // inputs, so an abandoned packet never leaks a flit during reset.
    assign v_raw      = (state_r == e_inj_burst) ? link.v_i[lock_r] : any_v;
    assign link.v_o   = v_raw & ~reset_i;
    assign grant_id_o = reset_i ? '0 : cur_id;
    assign busy_o     = (state_r == e_inj_burst) & ~reset_i;
    assign hs         = link.v_o & link.ready_and_i;

    always_comb begin
        link.ready_and_o = '0;
        if (!reset_i) begin
            link.ready_and_o[cur_id] = link.ready_and_i;
        end
    end

    assign hdr_len = len_width_p'(extract_len(max_flit_width_lp'(link.data_o),
                                              len_lsb_p, len_width_p));

    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        lock_n       = lock_r;
        last_grant_n = last_grant_r;
        case (state_r)
            e_inj_idle: begin
                if (hs) begin
                    last_grant_n = pick;
                    if (hdr_len != '0) begin
                        cnt_n   = hdr_len;
                        lock_n  = pick;
                        state_n = e_inj_burst;
                    end
                end
            end
            e_inj_burst: begin
                if (hs) begin
                    cnt_n = cnt_r - len_width_p'(1);
                    if (cnt_r == len_width_p'(1)) begin
                        state_n = e_inj_idle;
                    end
                end
            end
            default: state_n = e_inj_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= e_inj_idle;
            cnt_r        <= '0;
            lock_r       <= '0;
            last_grant_r <= lg_num_req_lp'(num_req_p - 1);
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            lock_r       <= lock_n;
            last_grant_r <= last_grant_n;
        end
    end
endmodule

// File: tb/tb_bp_coh_wormhole_inject_arb.sv
// Self-checking bench for bp_coh_wormhole_inject_arb. Each requester owns a
// queue of flits (whole packets); the reference model tracks packet ownership
// and the round-robin pointer and predicts every link output per cycle.
module tb_bp_coh_wormhole_inject_arb;
    localparam int N = 4;
    localparam int W = 64;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [1:0] grant_id_o;
    logic       busy_o;

    always #5 clk = ~clk;

    bp_coh_wormhole_inject_arb_if #(.num_req_p(N), .flit_width_p(W)) link();

    bp_coh_wormhole_inject_arb #(
        .num_req_p   (N),
        .flit_width_p(W),
        .len_width_p (4),
        .len_lsb_p   (8)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .link      (link),
        .grant_id_o(grant_id_o),
        .busy_o    (busy_o)
    );

    logic [63:0]  pq [N][$];
    logic [N-1:0] en;
    logic         rdy;
    int           m_last, m_owner, m_left;
    int           nvec = 0;
    int           nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int len);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[11:8] = 4'(len);
        pq[r].push_back(f);
        for (int k = 0; k < len; k++) pq[r].push_back({$urandom, $urandom});
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            link.v_i[i] = en[i] && (pq[i].size() > 0);
            link.data_i[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : {$urandom, $urandom};
        end
        link.ready_and_i = rdy;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) pq[i].delete();
        m_last  = N - 1;
        m_owner = 0;
        m_left  = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_v_o", 64'(link.v_o), 64'd0);
        chk("rst_ready", 64'(link.ready_and_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_grant", 64'(grant_id_o), 64'd0);
    endtask

    // Drive, settle, compare against the model, then advance the model.
    task automatic step_body();
        logic [N-1:0] v, oh;
        logic [63:0]  f;
        int           exp_id;
        logic         exp_v;
        drive();
        #1;
        for (int i = 0; i < N; i++) v[i] = en[i] && (pq[i].size() > 0);
        exp_v  = 1'b0;
        exp_id = m_last;
        if (m_left > 0) begin
            exp_id = m_owner;
            exp_v  = v[m_owner];
        end else begin
            for (int k = N; k >= 1; k--) begin
                if (v[(m_last + k) % N]) begin
                    exp_id = (m_last + k) % N;
                    exp_v  = 1'b1;
                end
            end
        end
        oh = N'(1) << exp_id;
        chk("v_o", 64'(link.v_o), 64'(exp_v));
        chk("grant_id", 64'(grant_id_o), 64'(exp_id));
        chk("busy", 64'(busy_o), 64'(m_left > 0));
        chk("ready_others", 64'(link.ready_and_o & ~oh), 64'd0);
        if (exp_v) begin
            chk("data_o", link.data_o, pq[exp_id][0]);
            chk("ready_grant", 64'(link.ready_and_o), 64'(rdy ? oh : '0));
        end
        if (exp_v && rdy) begin
            f = pq[exp_id].pop_front();
            if (m_left > 0) begin
                m_left--;
            end else begin
                m_last = exp_id;
                if (f[11:8] != 4'd0) begin
                    m_left  = int'(f[11:8]);
                    m_owner = exp_id;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        step_body();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        en   = '1;
        rdy  = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            done = (m_left == 0);
            for (int i = 0; i < N; i++) if (pq[i].size() > 0) done = 1'b0;
            if (!done) step();
        end
        nvec++;
        assert (done) else begin
            nerr++;
            $error("FAIL drain_timeout observed=pending expected=empty");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset held with every requester valid.
        reset_i = 1'b1;
        en      = '1;
        rdy     = 1'b1;
        model_reset();
        add_pkt(0, 0); add_pkt(0, 0);
        add_pkt(1, 0); add_pkt(2, 0); add_pkt(3, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive();
            #1;
            check_reset_outputs();
        end

        // Release; single-flit round robin 0,1,2,3,0.
        @(negedge clk);
        reset_i = 1'b0;
        step_body();
        for (int c = 0; c < 4; c++) step();
        drain();

        // Multi-flit lock: req1 len=3 while req2 waits.
        add_pkt(1, 3); add_pkt(2, 0);
        for (int c = 0; c < 6; c++) step();
        drain();

        // Backpressure during a len=2 packet.
        add_pkt(0, 2);
        for (int c = 0; c < 8; c++) begin
            rdy = (c % 2 == 0);
            step();
        end
        drain();

        // Maximum length with a 2-cycle source bubble on the locked requester.
        add_pkt(3, 15); add_pkt(0, 0); add_pkt(1, 0); add_pkt(2, 0);
        for (int c = 0; c < 26; c++) begin
            en = (c == 6 || c == 7) ? 4'b0111 : 4'b1111;
            step();
        end
        drain();

        // Async reset mid-burst after flit 2 of a len=5 packet.
        add_pkt(0, 5);
        step(); step();
        @(posedge clk);
        #1;
        chk("busy_before_reset", 64'(busy_o), 64'(m_left > 0));
        #2;
        reset_i = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        for (int i = 0; i < N; i++) add_pkt(i, 0);
        @(negedge clk);
        drive();
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_i = 1'b0;
        step_body();
        for (int c = 0; c < 3; c++) step();
        drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() < 4 && $urandom_range(0, 3) == 0)
                    add_pkt(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                            : int'($urandom_range(0, 2)));
            end
            en  = N'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/bp_coh_wormhole_inject_arb.md
Name: bp_coh_wormhole_inject_arb

Overview:
- Packet-granular round-robin arbiter that shares one coherence-NoC ready_and injection link among num_req_p requesters (LCE/CCE sources inside a tile node).
- Wormhole packets (header flit plus len payload flits) stay contiguous: the grant is locked from the header handshake until the last flit is accepted.
- Sits between tile-internal packet sources and the router's local input port (lce_req/cmd/resp links).

Parameters:
- num_req_p, 4, number of requesters (at least 2).
- flit_width_p, 64, flit width in bits.
- len_width_p, 4, width of the wormhole length field (payload flits after the header).
- len_lsb_p, 8, bit position of the length-field LSB in the header flit.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- data_i  in  num_req_p*flit_width_p  per-requester flit.
- v_i  in  num_req_p  per-requester valid.
- ready_and_o  out  num_req_p  per-requester ready_and.
- data_o  out  flit_width_p  muxed flit to router.
- v_o  out  1  valid to router.
- ready_and_i  in  1  router ready_and.
- grant_id_o  out  log2(num_req_p)  index currently driving data_o.
- busy_o  out  1  packet in progress (state BURST).

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert is provided upstream):
  - state=IDLE, last_grant_r=num_req_p-1 (so requester 0 has top priority first), cnt_r=0.
  - While reset_i=1: v_o=0, ready_and_o=0, busy_o=0, grant_id_o=0.
- Handshake: a flit transfers when v_o & ready_and_i.
  - v_o, data_o and grant_id_o never depend on ready_and_i.
  - ready_and_o[g]=ready_and_i for the granted index only; all other bits are 0.
  - The path is zero-latency and combinational; the block has no storage.
- IDLE:
  - pick = first i with v_i[i]=1, searching from last_grant_r+1 modulo num_req_p.
  - If no v_i is set: v_o=0 and grant_id_o holds last_grant_r.
  - Otherwise drive data_o=data_i[pick], v_o=1, grant_id_o=pick.
  - On handshake with len = data_i[pick][len_lsb_p +: len_width_p]: last_grant_r<=pick.
    - If len==0: stay in IDLE (single-flit packet).
    - Else: cnt_r<=len, lock_r<=pick, go to BURST.
  - Without a handshake, pick may change on the next cycle as v_i changes. The grant and priority pointer do not advance.
- BURST:
  - Only lock_r is connected; grant_id_o=lock_r; busy_o=1.
  - Other requesters' v_i are ignored (their ready_and_o=0).
  - On handshake: cnt_r<=cnt_r-1. If cnt_r==1, go to IDLE.
  - v_i[lock_r]=0 mid-packet produces bubbles (v_o=0). The lock is held indefinitely; there is no timeout.
- Width rules:
  - cnt_r is len_width_p bits.
  - The maximum packet is 2^len_width_p flits, e.g. len=15 gives 16 flits.
  - cnt_r never underflows because the BURST exit is at cnt_r==1.
- Fairness: each requester waits at most num_req_p-1 packets between grants while it holds v_i high.
- Reset asserted mid-packet: the packet is abandoned and the block returns to IDLE immediately. Downstream recovery is by the system-wide reset.

Decomposition:
- Shared package bp_coh_inject_arb_pkg holds:
  - the state enum (e_inj_idle, e_inj_burst);
  - a len-extraction function parameterised by len_lsb_p and len_width_p.
- One sub-module, bp_rr_pick, does the combinational rotate/priority-encode. Inputs are v_i and last_grant; outputs are pick and any_v.
- The FSM, counter and mux live in the top module.

Test Plan:
- Reset and idle: hold reset_i=1 with all v_i=1, then release → v_o=0 during reset. The first grant goes to requester 0 on the first cycle after release.
- Single-flit round-robin: all 4 requesters hold len=0 headers with ready_and_i=1 → grants 0,1,2,3,0 on consecutive cycles; busy_o stays 0.
- Multi-flit lock: req1 sends len=3 while req2 is valid throughout → 4 consecutive req1 flits with grant_id_o=1 and ready_and_o[2]=0. The req2 header follows on the next cycle.
- Backpressure: ready_and_i toggles 1,0,1,0 during a len=2 packet → exactly 3 transfers, cnt_r decrements only on handshake cycles, and data_o is stable while stalled.
- Source bubble and maximum length: a len=15 packet with v_i[lock] dropped for 2 cycles → 16 flits total, and no other requester is granted during the bubble.
- Async reset mid-BURST: reset_i asserted in the middle of a clock period after flit 2 of len=5 → v_o=0 and busy_o=0 immediately, without waiting for a clock edge. After release the arbiter returns to IDLE with requester 0 at top priority.
